// File: rtl/mdu_issue_ctrl_pkg.sv
// mdu_issue_ctrl_pkg
// Shared definitions for the MDU issue controller: the M-extension funct3
// encodings (mirroring the named constants the core keeps in riscv_defines.vh)
// and the operand/result widths used on the MDU boundary.
// No ports; imported by mdu_issue_ctrl.
package mdu_issue_ctrl_pkg;

    localparam int XLEN = 32;

    // M-extension funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl
// Requester-side controller for the multiply/divide unit. Accepts one
// M-extension op at a time from execute, runs the MDU start/done/ack
// handshake with operands held in registers, picks the architectural 32-bit
// result by funct3 and offers it to writeback over a valid/ready port.
// A flush kills the op's writeback but never abandons the MDU mid-operation.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         op handshake from execute
//   req_funct3/rs1/rs2/rd       op fields
//   flush                       kill in-flight op
//   stall                       hold pipeline front end
//   mdu_start/mdu_ack           MDU handshake outputs
//   mdu_funct3/mdu_a/mdu_b      latched op towards the MDU
//   mdu_busy/mdu_done           MDU status
//   mdu_product/quotient/remainder  MDU results
//   wb_valid/wb_ready/wb_rd/wb_data writeback port
//   timeout_err                 sticky watchdog flag
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic              stall,
    output logic              mdu_start,
    output logic              mdu_ack,
    output logic [2:0]        mdu_funct3,
    output logic [XLEN-1:0]   mdu_a,
    output logic [XLEN-1:0]   mdu_b,
    input  logic              mdu_busy,
    input  logic              mdu_done,
    input  logic [2*XLEN-1:0] mdu_product,
    input  logic [XLEN-1:0]   mdu_quotient,
    input  logic [XLEN-1:0]   mdu_remainder,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;

    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic            killed_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic [XLEN-1:0] res_q;
    logic            accept;
    logic            in_flight;

    // Maps funct3 onto the MDU output that holds the architectural result.
    // Signedness and divide corner cases are already resolved by the MDU.
    function automatic logic [XLEN-1:0] select_result(
        input logic [2:0]        f3,
        input logic [2*XLEN-1:0] product,
        input logic [XLEN-1:0]   quotient,
        input logic [XLEN-1:0]   remainder
    );
        logic [XLEN-1:0] r;
        case (f3)
            F3_MUL:                     r = product[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: r = product[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:            r = quotient;
            default:                    r = remainder;
        endcase
        return r;
    endfunction

    // Handshake outputs decode straight from the state register; a flush in
    // WB suppresses wb_valid in the same cycle so nothing gets written.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !mdu_busy && !flush;
        accept    = req_valid && req_ready;
        in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_ACK);
        stall     = (state_q != ST_IDLE) || (req_valid && !req_ready);
        mdu_start = (state_q == ST_ISSUE);
        mdu_ack   = (state_q == ST_ACK);
        wb_valid  = (state_q == ST_WB) && !flush;
        wb_data   = res_q;
    end

    // Next-state logic. ACK is held until the MDU has dropped done, and a
    // flush arriving in that final ACK cycle still counts as a kill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mdu_done) state_d = ST_ACK;
            ST_ACK: begin
                if (!mdu_done) state_d = (killed_q || flush) ? ST_IDLE : ST_WB;
            end
            ST_WB:    if (flush || wb_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, operand latches, kill flag, result capture and the saturating
    // watchdog. The watchdog only flags; the FSM keeps waiting for done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            killed_q    <= 1'b0;
            wd_cnt_q    <= '0;
            timeout_err <= 1'b0;
            res_q       <= '0;
            mdu_funct3  <= '0;
            mdu_a       <= '0;
            mdu_b       <= '0;
            wb_rd       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mdu_funct3 <= req_funct3;
                mdu_a      <= req_rs1;
                mdu_b      <= req_rs2;
                wb_rd      <= req_rd;
                killed_q   <= 1'b0;
                wd_cnt_q   <= '0;
            end else begin
                if (flush && in_flight) killed_q <= 1'b1;
                if (state_q == ST_WAIT && wd_cnt_q != WD_LIMIT) wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (wd_cnt_q == WD_LIMIT) timeout_err <= 1'b1;
            if (state_q == ST_WAIT && mdu_done) begin
                res_q <= select_result(mdu_funct3, mdu_product, mdu_quotient, mdu_remainder);
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl
// Directed bench for mdu_issue_ctrl. A small behavioural MDU (updated on the
// falling edge) returns whatever product/quotient/remainder the current
// vector loads into it, after a programmable latency, and holds done until
// it sees ack. Expected writeback values are hand-computed per vector.
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        mdu_start;
    logic        mdu_ack;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    logic        mdl_busy = 1'b0;
    logic        mdl_done = 1'b0;
    int          mdl_cnt = 0;
    int          mdl_latency = 3;
    logic        mdl_never_done = 1'b0;
    logic [63:0] mdl_product = '0;
    logic [31:0] mdl_quotient = '0;
    logic [31:0] mdl_remainder = '0;

    int n_checks = 0;
    int n_errors = 0;

    mdu_issue_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .flush(flush), .stall(stall),
        .mdu_start(mdu_start), .mdu_ack(mdu_ack), .mdu_funct3(mdu_funct3),
        .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_busy(mdl_busy), .mdu_done(mdl_done),
        .mdu_product(mdl_product), .mdu_quotient(mdl_quotient), .mdu_remainder(mdl_remainder),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural MDU: start -> busy, done after mdl_latency falling edges,
    // done held until ack is observed, shares the controller reset.
    always @(negedge clk) begin
        if (rst) begin
            mdl_busy = 1'b0;
            mdl_done = 1'b0;
            mdl_cnt  = 0;
        end else if (mdl_done) begin
            if (mdu_ack) begin
                mdl_done = 1'b0;
                mdl_busy = 1'b0;
            end
        end else if (mdl_busy) begin
            if (!mdl_never_done) begin
                if (mdl_cnt <= 1) mdl_done = 1'b1;
                else mdl_cnt = mdl_cnt - 1;
            end
        end else if (mdu_start) begin
            mdl_busy = 1'b1;
            mdl_cnt  = mdl_latency;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issues one op, follows it through the handshake and checks the
    // writeback, optionally holding wb_ready low for hold_cycles.
    task automatic applyStimulus(
        input string       tag,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  rd,
        input logic [63:0] product,
        input logic [31:0] quotient,
        input logic [31:0] remainder,
        input logic [31:0] expected,
        input int          hold_cycles
    );
        logic stall_dropped;
        logic seen_wb;
        logic hold_bad;
        mdl_product   = product;
        mdl_quotient  = quotient;
        mdl_remainder = remainder;
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        #1;
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rs1   = 32'h0BAD_0BAD;
        req_rs2   = 32'h0BAD_0BAD;
        checkOutput({tag, "_start_c1"}, 64'(mdu_start), 64'd1);
        checkOutput({tag, "_operands"}, {mdu_a, mdu_b}, {a, b});
        checkOutput({tag, "_funct3"}, 64'(mdu_funct3), 64'(f3));
        @(posedge clk);
        #1;
        checkOutput({tag, "_start_once"}, 64'(mdu_start), 64'd0);
        stall_dropped = 1'b0;
        seen_wb = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wb_valid) begin
                seen_wb = 1'b1;
                break;
            end
            if (!stall) stall_dropped = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_wb_seen"}, 64'(seen_wb), 64'd1);
        checkOutput({tag, "_stall_held"}, 64'(stall_dropped), 64'd0);
        checkOutput({tag, "_wb_data"}, 64'(wb_data), 64'(expected));
        checkOutput({tag, "_wb_rd"}, 64'(wb_rd), 64'(rd));
        if (hold_cycles > 0) begin
            hold_bad = 1'b0;
            req_valid = 1'b1;
            repeat (hold_cycles) begin
                @(posedge clk);
                #1;
                if (!wb_valid || wb_data !== expected || wb_rd !== rd || mdu_start || req_ready || !stall)
                    hold_bad = 1'b1;
            end
            checkOutput({tag, "_hold_stable"}, 64'(hold_bad), 64'd0);
        end
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        checkOutput({tag, "_wb_done"}, 64'(wb_valid), 64'd0);
        checkOutput({tag, "_idle"}, {62'd0, stall, req_ready}, 64'b01);
    endtask

    initial begin
        logic ack_seen;
        logic wb_seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_handshake", {61'd0, mdu_start, mdu_ack, wb_valid}, 64'd0);
        checkOutput("reset_timeout", 64'(timeout_err), 64'd0);
        checkOutput("reset_operands", {mdu_a, mdu_b}, 64'd0);
        checkOutput("reset_wb", {27'd0, wb_rd, wb_data}, 64'd0);
        checkOutput("reset_ready", {62'd0, req_ready, stall}, 64'b10);

        mdl_latency = 3;
        applyStimulus("mul", 3'b000, 32'd7, 32'd6, 5'd5, 64'd42, 32'hDEAD0001, 32'hDEAD0002, 32'h0000002A, 0);
        applyStimulus("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 64'hFFFFFFFE_00000001,
                      32'hDEAD0001, 32'hDEAD0002, 32'hFFFFFFFE, 0);
        applyStimulus("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 64'h00000000_00000001,
                      32'hDEAD0001, 32'hDEAD0002, 32'h00000000, 0);
        applyStimulus("mulhsu", 3'b010, 32'h1234, 32'h5678, 5'd11, 64'hAAAA5555_0000BEEF,
                      32'hDEAD0001, 32'hDEAD0002, 32'hAAAA5555, 0);
        mdl_latency = 5;
        applyStimulus("divu", 3'b101, 32'd100, 32'd7, 5'd12, 64'h12345678_87654321, 32'd14, 32'd2, 32'd14, 0);
        applyStimulus("remu", 3'b111, 32'd100, 32'd7, 5'd13, 64'h12345678_87654321, 32'd14, 32'd2, 32'd2, 0);
        applyStimulus("div0", 3'b100, 32'd100, 32'd0, 5'd14, 64'h12345678_87654321, 32'hFFFFFFFF, 32'd100,
                      32'hFFFFFFFF, 0);
        applyStimulus("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd15, 64'h12345678_87654321, 32'hFFFFFFFD,
                      32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        mdl_latency = 2;
        applyStimulus("hold", 3'b000, 32'd3, 32'd4, 5'd31, 64'd12, 32'hDEAD0001, 32'hDEAD0002, 32'd12, 5);

        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        #1;
        checkOutput("flush_idle_ready", {62'd0, req_ready, stall}, 64'b01);
        @(posedge clk);
        #1;
        checkOutput("flush_idle_nostart", 64'(mdu_start), 64'd0);
        req_valid = 1'b0;
        flush     = 1'b0;

        mdl_latency   = 6;
        mdl_product   = 64'd99;
        mdl_quotient  = 32'd1;
        mdl_remainder = 32'd2;
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = 3'b000;
        req_rs1    = 32'd9;
        req_rs2    = 32'd11;
        req_rd     = 5'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ack_seen = 1'b0;
        wb_seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (mdu_ack) ack_seen = 1'b1;
            if (wb_valid) wb_seen = 1'b1;
        end
        checkOutput("flush_ack_issued", 64'(ack_seen), 64'd1);
        checkOutput("flush_no_wb", 64'(wb_seen), 64'd0);
        checkOutput("flush_back_idle", {62'd0, req_ready, stall}, 64'b10);
        mdl_latency = 3;
        applyStimulus("after_flush", 3'b000, 32'd7, 32'd6, 5'd8, 64'd42, 32'hDEAD0001, 32'hDEAD0002, 32'h2A, 0);

        mdl_never_done = 1'b1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = 3'b101;
        req_rs1    = 32'd1;
        req_rs2    = 32'd1;
        req_rd     = 5'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checkOutput("timeout_early", 64'(timeout_err), 64'd0);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("timeout_set", 64'(timeout_err), 64'd1);
        checkOutput("timeout_waiting", {61'd0, stall, mdu_ack, wb_valid}, 64'b100);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("timeout_sticky", 64'(timeout_err), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        mdl_never_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_timeout_clr", 64'(timeout_err), 64'd0);
        checkOutput("rst_ready", {62'd0, req_ready, stall}, 64'b10);
        checkOutput("rst_regs", {mdu_a, wb_data}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
